pc_update_unit: RTL



---
 rtl/pc_pkg.sv | 19 +
 rtl/pc_update_unit_if.sv | 28 ++
 rtl/branch_cond_eval.sv | 20 ++
 rtl/pc_update_unit.sv | 90 +++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC update stage.
package pc_pkg;

  typedef enum logic [1:0] {
    BR_EQ  = 2'd0,
    BR_NE  = 2'd1,
    BR_LEZ = 2'd2,
    BR_GT  = 2'd3
  } branch_type_e;

  typedef enum logic {
    PC_RUN = 1'b0,
    PC_EXC = 1'b1
  } pc_state_e;

  localparam logic [1:0]  CAUSE_MISALIGN     = 2'd3;
  localparam logic [31:0] DEFAULT_EXC_VECTOR = 32'h0000_0080;

endpackage

// File: rtl/pc_update_unit_if.sv
// Control/data bundle between the control unit, the PC-source selector and the PC stage.
interface pc_update_unit_if;
  import pc_pkg::*;

  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_type;
  logic        zero;
  logic        neg;
  logic        exc_in;
  logic [1:0]  exc_code_in;
  logic [31:0] pc;
  logic [31:0] epc;
  logic [1:0]  cause;
  logic        in_exc;
  logic        pc_loaded;

  modport master (
    output pc_next, pc_write, pc_write_cond, branch_type, zero, neg, exc_in, exc_code_in,
    input  pc, epc, cause, in_exc, pc_loaded
  );

  modport slave (
    input  pc_next, pc_write, pc_write_cond, branch_type, zero, neg, exc_in, exc_code_in,
    output pc, epc, cause, in_exc, pc_loaded
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition from the ALU flags.
module branch_cond_eval
  import pc_pkg::*;
(
  input  branch_type_e branch_type,
  input  logic         zero,
  input  logic         neg,
  output logic         cond_true
);
  always_comb begin
    cond_true = 1'b0;
    unique case (branch_type)
      BR_EQ:  cond_true = zero;
      BR_NE:  cond_true = !zero;
      BR_LEZ: cond_true = zero | neg;
      BR_GT:  cond_true = !zero & !neg;
      default: cond_true = 1'b0;
    endcase
  end
endmodule

// File: rtl/pc_update_unit.sv
// PC register stage: resolves write strobes, traps misaligned targets and
// external exceptions, and holds in EXC for a fixed number of cycles.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR       = DEFAULT_EXC_VECTOR,
  parameter int unsigned EXC_ENTRY_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  pc_update_unit_if.slave bus
);
  localparam int unsigned     CNT_W    = (EXC_ENTRY_CYCLES > 1) ? $clog2(EXC_ENTRY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXC_ENTRY_CYCLES - 1);

  pc_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pc_q;
  logic [31:0]      epc_q;
  logic [1:0]       cause_q;
  logic             in_exc_q;
  logic             loaded_q;

  logic cond_true;
  logic we;
  logic mis;
  logic take_exc;
  logic pc_en;

  branch_cond_eval u_cond (
    .branch_type (branch_type_e'(bus.branch_type)),
    .zero        (bus.zero),
    .neg         (bus.neg),
    .cond_true   (cond_true)
  );

  assign we       = bus.pc_write | (bus.pc_write_cond & cond_true);
  assign mis      = we & (bus.pc_next[1:0] != 2'b00);
  assign take_exc = (state == PC_RUN) & (bus.exc_in | mis);
  // Exception entry reloads pc even if it already holds the vector.
  assign pc_en    = (state == PC_RUN) & (bus.exc_in | we);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= PC_RUN;
      cnt      <= '0;
      pc_q     <= RESET_PC;
      epc_q    <= '0;
      cause_q  <= '0;
      in_exc_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      loaded_q <= pc_en;
      case (state)
        PC_RUN: begin
          if (take_exc) begin
            epc_q    <= pc_q;
            cause_q  <= bus.exc_in ? bus.exc_code_in : CAUSE_MISALIGN;
            pc_q     <= EXC_VECTOR;
            state    <= PC_EXC;
            in_exc_q <= 1'b1;
            cnt      <= CNT_INIT;
          end else if (we) begin
            pc_q <= bus.pc_next;
          end
        end
        PC_EXC: begin
          if (cnt == '0) begin
            state    <= PC_RUN;
            in_exc_q <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state    <= PC_RUN;
          in_exc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.epc       = epc_q;
  assign bus.cause     = cause_q;
  assign bus.in_exc    = in_exc_q;
  assign bus.pc_loaded = loaded_q;

endmodule
